// File: rtl/nfu_pkg.sv
// Shared types, record layout and helpers for the neuron fire unit.
package nfu_pkg;

  localparam int unsigned NR_WIDTH       = 56;
  localparam int unsigned NR_DEPTH       = 16;
  localparam int unsigned NR_AW          = $clog2(NR_DEPTH);
  localparam int unsigned T_WIDTH        = 16;
  localparam int unsigned REFRACT_PERIOD = 2;

  localparam int unsigned FIELD_W  = 16;
  localparam int unsigned REF_W    = 4;
  localparam int unsigned LEAK_W   = 4;
  localparam int unsigned ACC_LSB  = 40;
  localparam int unsigned V_LSB    = 24;
  localparam int unsigned TH_LSB   = 8;
  localparam int unsigned REF_LSB  = 4;
  localparam int unsigned LEAK_LSB = 0;

  // Field order matches the bit offsets above (ACC in the top bits).
  typedef struct packed {
    logic signed [FIELD_W-1:0] acc;
    logic signed [FIELD_W-1:0] v;
    logic signed [FIELD_W-1:0] th;
    logic        [REF_W-1:0]   refr;
    logic        [LEAK_W-1:0]  leak;
  } neuron_rec_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CALC,
    S_WR,
    S_EMIT,
    S_DONE
  } fsm_state_t;

  function automatic logic signed [FIELD_W-1:0] sat16(input logic signed [FIELD_W+1:0] x);
    if (x > 18'sd32767)       return 16'sh7fff;
    else if (x < -18'sd32768) return 16'sh8000;
    return x[FIELD_W-1:0];
  endfunction

endpackage

// File: rtl/neuron_fire_unit_if.sv
// Neuron-RAM port and spike-event handshake of the fire unit.
interface neuron_fire_unit_if;
  import nfu_pkg::*;

  logic [NR_AW-1:0]    nr_addr;
  logic                nr_we;
  logic [NR_WIDTH-1:0] nr_write;
  logic [NR_WIDTH-1:0] nr_read;
  logic                spike_valid;
  logic                spike_ready;
  logic [NR_AW-1:0]    spike_id;
  logic [T_WIDTH-1:0]  spike_time;

  modport master (
    output nr_addr, nr_we, nr_write, spike_valid, spike_id, spike_time,
    input  nr_read, spike_ready
  );

  modport slave (
    input  nr_addr, nr_we, nr_write, spike_valid, spike_id, spike_time,
    output nr_read, spike_ready
  );
endinterface

// File: rtl/neuron_update_alu.sv
// Combinational per-neuron update: leak, integrate, saturate, refractory, threshold.
module neuron_update_alu
  import nfu_pkg::*;
(
  input  neuron_rec_t i_rec,
  output neuron_rec_t o_rec,
  output logic        o_fire
);

  logic signed [FIELD_W-1:0] w_leak16;
  logic signed [FIELD_W+1:0] w_v;
  logic signed [FIELD_W+1:0] w_leak;
  logic signed [FIELD_W+1:0] w_acc;
  logic signed [FIELD_W+1:0] w_sum;
  logic signed [FIELD_W-1:0] w_v_sat;

  // 18-bit sum cannot overflow for any 16-bit V/ACC combination.
  always_comb begin
    w_leak16 = $signed(i_rec.v) >>> i_rec.leak;
    w_v      = {{2{i_rec.v[FIELD_W-1]}}, i_rec.v};
    w_leak   = {{2{w_leak16[FIELD_W-1]}}, w_leak16};
    w_acc    = {{2{i_rec.acc[FIELD_W-1]}}, i_rec.acc};
    w_sum    = w_v - w_leak + w_acc;
    w_v_sat  = sat16(w_sum);

    o_rec     = i_rec;
    o_rec.acc = '0;
    o_fire    = 1'b0;
    if (i_rec.refr != '0) begin
      o_rec.v    = '0;
      o_rec.refr = i_rec.refr - REF_W'(1);
    end else if ($signed(w_v_sat) >= $signed(i_rec.th)) begin
      o_fire     = 1'b1;
      o_rec.v    = '0;
      o_rec.refr = REF_W'(REFRACT_PERIOD);
    end else begin
      o_rec.v = w_v_sat;
    end
  end

endmodule

// File: rtl/neuron_fire_unit.sv
// Per-timestep sweep over neuron RAM: read, update, write back, emit spikes.
module neuron_fire_unit
  import nfu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               freeze,
  input  logic [T_WIDTH-1:0] time_index,
  output logic               busy,
  output logic               done,
  neuron_fire_unit_if.master bus
);

  fsm_state_t          r_state;
  logic [NR_AW-1:0]    r_cnt;
  logic                r_busy;
  logic                r_done;
  logic                r_nr_we;
  logic [NR_WIDTH-1:0] r_nr_write;
  logic                r_fire;
  logic                r_spike_valid;
  logic [NR_AW-1:0]    r_spike_id;
  logic [T_WIDTH-1:0]  r_spike_time;

  neuron_rec_t w_rd_rec;
  neuron_rec_t w_new_rec;
  logic        w_fire;
  logic        w_last;

  assign w_rd_rec = bus.nr_read;
  assign w_last   = (r_cnt == NR_AW'(NR_DEPTH - 1));

  neuron_update_alu u_alu (
    .i_rec  (w_rd_rec),
    .o_rec  (w_new_rec),
    .o_fire (w_fire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_nr_we       <= 1'b0;
      r_nr_write    <= '0;
      r_fire        <= 1'b0;
      r_spike_valid <= 1'b0;
      r_spike_id    <= '0;
      r_spike_time  <= '0;
    end else if (!freeze) begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_spike_time <= time_index;
            r_cnt        <= '0;
            r_busy       <= 1'b1;
            r_state      <= S_RD;
          end
        end
        S_RD: r_state <= S_CALC;
        S_CALC: begin
          r_nr_write <= w_new_rec;
          r_fire     <= w_fire;
          r_nr_we    <= 1'b1;
          r_state    <= S_WR;
        end
        S_WR: begin
          r_nr_we <= 1'b0;
          if (r_fire) begin
            r_spike_valid <= 1'b1;
            r_spike_id    <= r_cnt;
            r_state       <= S_EMIT;
          end else if (w_last) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt   <= r_cnt + NR_AW'(1);
            r_state <= S_RD;
          end
        end
        S_EMIT: begin
          if (bus.spike_ready) begin
            r_spike_valid <= 1'b0;
            r_fire        <= 1'b0;
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_cnt   <= r_cnt + NR_AW'(1);
              r_state <= S_RD;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign bus.nr_addr     = r_cnt;
  // A frozen write is suppressed here and re-issued once freeze drops.
  assign bus.nr_we       = r_nr_we & ~freeze;
  assign bus.nr_write    = r_nr_write;
  assign bus.spike_valid = r_spike_valid;
  assign bus.spike_id    = r_spike_id;
  assign bus.spike_time  = r_spike_time;

endmodule

// File: tb/tb_neuron_fire_unit.sv
// Directed bench for neuron_fire_unit with a synchronous neuron-RAM model.
module tb_neuron_fire_unit;
  import nfu_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               freeze;
  logic [T_WIDTH-1:0] time_index;
  logic               busy;
  logic               done;

  neuron_fire_unit_if u_if ();

  neuron_fire_unit dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .freeze     (freeze),
    .time_index (time_index),
    .busy       (busy),
    .done       (done),
    .bus        (u_if.master)
  );

  always #5 clk = ~clk;

  logic [NR_WIDTH-1:0] mem [NR_DEPTH];
  logic [NR_WIDTH-1:0] img [NR_DEPTH];
  logic                load = 1'b0;
  int                  wr_cnt;
  int                  sp_cnt;
  logic [NR_AW-1:0]    last_id;
  logic [T_WIDTH-1:0]  last_time;
  int                  n_tests = 0;
  int                  n_fail  = 0;

  // RAM model plus write / spike-handshake observers.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < int'(NR_DEPTH); i++) mem[i] <= img[i];
      wr_cnt    <= 0;
      sp_cnt    <= 0;
      last_id   <= '1;
      last_time <= '1;
    end else begin
      if (u_if.nr_we) begin
        mem[u_if.nr_addr] <= u_if.nr_write;
        wr_cnt            <= wr_cnt + 1;
      end
      if (u_if.spike_valid && u_if.spike_ready) begin
        sp_cnt    <= sp_cnt + 1;
        last_id   <= u_if.spike_id;
        last_time <= u_if.spike_time;
      end
    end
    u_if.nr_read <= mem[u_if.nr_addr];
  end

  function automatic logic [NR_WIDTH-1:0] mk(input int acc, input int v, input int th,
                                             input int rf, input int lk);
    return {16'(acc), 16'(v), 16'(th), 4'(rf), 4'(lk)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic base_img();
    for (int i = 0; i < int'(NR_DEPTH); i++) img[i] = mk(0, 0, 100, 0, 0);
  endtask

  task automatic load_img();
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic do_start(input logic [T_WIDTH-1:0] t);
    @(negedge clk); time_index = t; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Counts cycles until done, optionally re-pulsing start at cycle pulse_at.
  task automatic wait_done(input int c0, input int pulse_at, output int cyc);
    cyc = c0;
    while (done !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = (cyc == pulse_at);
    end
    start = 1'b0;
    chk("done_seen", 64'(done), 64'(1));
  endtask

  task automatic wait_spike(output int cyc);
    cyc = 1;
    while (u_if.spike_valid !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("spike_reached", 64'(u_if.spike_valid), 64'(1));
  endtask

  initial begin
    int cyc;
    int dcount;
    reset = 1'b1; start = 1'b0; freeze = 1'b0; time_index = '0;
    u_if.spike_ready = 1'b1;
    base_img();
    repeat (3) @(negedge clk);

    chk("rst_busy",   64'(busy), 64'(0));
    chk("rst_done",   64'(done), 64'(0));
    chk("rst_we",     64'(u_if.nr_we), 64'(0));
    chk("rst_addr",   64'(u_if.nr_addr), 64'(0));
    chk("rst_write",  64'(u_if.nr_write), 64'(0));
    chk("rst_valid",  64'(u_if.spike_valid), 64'(0));
    chk("rst_id",     64'(u_if.spike_id), 64'(0));
    chk("rst_time",   64'(u_if.spike_time), 64'(0));
    load_img();
    @(negedge clk); reset = 1'b0;

    // All-quiet sweep, with a stray start mid-sweep.
    do_start(16'd7);
    chk("busy_after_start", 64'(busy), 64'(1));
    wait_done(1, 10, cyc);
    chk("quiet_cycles", 64'(cyc), 64'(49));
    chk("quiet_writes", 64'(wr_cnt), 64'(16));
    chk("quiet_spikes", 64'(sp_cnt), 64'(0));
    chk("quiet_rec15",  64'(mem[15]), 64'(mk(0, 0, 100, 0, 0)));
    chk("quiet_time",   64'(u_if.spike_time), 64'(7));
    @(negedge clk);
    chk("quiet_busy_end", 64'(busy), 64'(0));
    chk("quiet_done_end", 64'(done), 64'(0));

    // Neuron 3 fires.
    img[3] = mk(20, 90, 100, 0, 4);
    load_img();
    do_start(16'd7);
    wait_done(1, 0, cyc);
    chk("n3_cycles", 64'(cyc), 64'(50));
    chk("n3_rec",    64'(mem[3]), 64'(mk(0, 0, 100, 2, 4)));
    chk("n3_spikes", 64'(sp_cnt), 64'(1));
    chk("n3_id",     64'(last_id), 64'(3));
    chk("n3_time",   64'(last_time), 64'(7));
    chk("n3_writes", 64'(wr_cnt), 64'(16));

    // Refractory countdown, then fire again.
    img[3] = mk(500, 0, 100, 2, 4);
    load_img(); do_start(16'd8); wait_done(1, 0, cyc);
    chk("ref2_rec",    64'(mem[3]), 64'(mk(0, 0, 100, 1, 4)));
    chk("ref2_spikes", 64'(sp_cnt), 64'(0));
    img[3] = mk(500, 0, 100, 1, 4);
    load_img(); do_start(16'd9); wait_done(1, 0, cyc);
    chk("ref1_rec",    64'(mem[3]), 64'(mk(0, 0, 100, 0, 4)));
    chk("ref1_spikes", 64'(sp_cnt), 64'(0));
    img[3] = mk(500, 0, 100, 0, 4);
    load_img(); do_start(16'd10); wait_done(1, 0, cyc);
    chk("ref0_rec",    64'(mem[3]), 64'(mk(0, 0, 100, 2, 4)));
    chk("ref0_spikes", 64'(sp_cnt), 64'(1));
    chk("ref0_time",   64'(last_time), 64'(10));

    // Saturation and signed leak.
    base_img();
    img[0] = mk(32000, 32000, 32767, 0, 15);
    img[1] = mk(-1000, -32768, 100, 0, 15);
    img[2] = mk(-3, 10, 5, 0, 1);
    img[4] = mk(0, -100, 0, 0, 3);
    load_img(); do_start(16'd3); wait_done(1, 0, cyc);
    chk("sat_cycles", 64'(cyc), 64'(50));
    chk("sat_pos",    64'(mem[0]), 64'(mk(0, 0, 32767, 2, 15)));
    chk("sat_neg",    64'(mem[1]), 64'(mk(0, -32768, 100, 0, 15)));
    chk("leak_pos",   64'(mem[2]), 64'(mk(0, 2, 5, 0, 1)));
    chk("leak_neg",   64'(mem[4]), 64'(mk(0, -87, 0, 0, 3)));
    chk("sat_spikes", 64'(sp_cnt), 64'(1));
    chk("sat_id",     64'(last_id), 64'(0));

    // Back-pressure on neuron 5.
    base_img();
    img[5] = mk(20, 90, 100, 0, 4);
    load_img();
    u_if.spike_ready = 1'b0;
    do_start(16'd11);
    wait_spike(cyc);
    chk("emit_cycle", 64'(cyc), 64'(19));
    repeat (10) begin
      @(negedge clk);
      chk("emit_hold", 64'({u_if.spike_valid, u_if.spike_id, u_if.spike_time, u_if.nr_we}),
          64'({1'b1, 4'd5, 16'd11, 1'b0}));
    end
    chk("emit_writes", 64'(wr_cnt), 64'(6));
    u_if.spike_ready = 1'b1;
    @(negedge clk);
    chk("emit_release", 64'(u_if.spike_valid), 64'(0));
    chk("emit_next",    64'(u_if.nr_addr), 64'(6));
    wait_done(0, 0, cyc);
    chk("emit_rec",    64'(mem[5]), 64'(mk(0, 0, 100, 2, 4)));
    chk("emit_spikes", 64'(sp_cnt), 64'(1));
    chk("emit_id",     64'(last_id), 64'(5));
    chk("emit_total",  64'(wr_cnt), 64'(16));

    // Reset while a spike is pending.
    load_img();
    u_if.spike_ready = 1'b0;
    do_start(16'd12);
    wait_spike(cyc);
    @(negedge clk); reset = 1'b1;
    #1;
    chk("rstmid_valid", 64'(u_if.spike_valid), 64'(0));
    chk("rstmid_busy",  64'(busy), 64'(0));
    chk("rstmid_addr",  64'(u_if.nr_addr), 64'(0));
    @(negedge clk); reset = 1'b0; u_if.spike_ready = 1'b1;
    dcount = 0;
    repeat (60) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dcount++;
    end
    chk("rstmid_idle",   64'(dcount), 64'(0));
    chk("rstmid_writes", 64'(wr_cnt), 64'(6));
    chk("rstmid_spikes", 64'(sp_cnt), 64'(0));
    @(negedge clk); reset = 1'b1; start = 1'b1;
    @(negedge clk); reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", 64'(busy), 64'(0));

    // Freeze across the first write.
    base_img();
    load_img();
    do_start(16'd13);
    cyc = 1;
    while (u_if.nr_we !== 1'b1 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("frz_wr_cycle", 64'(cyc), 64'(3));
    freeze = 1'b1;
    #1;
    chk("frz_we_low", 64'(u_if.nr_we), 64'(0));
    repeat (5) begin
      @(negedge clk);
      chk("frz_hold", 64'({u_if.nr_we, u_if.nr_addr, busy}), 64'({1'b0, 4'd0, 1'b1}));
    end
    chk("frz_no_write", 64'(wr_cnt), 64'(0));
    freeze = 1'b0;
    #1;
    chk("frz_we_back", 64'(u_if.nr_we), 64'(1));
    @(negedge clk);
    chk("frz_one_write", 64'(wr_cnt), 64'(1));
    chk("frz_we_off",    64'(u_if.nr_we), 64'(0));
    wait_done(0, 0, cyc);
    chk("frz_total", 64'(wr_cnt), 64'(16));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
